wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:
//  req0 = ALU result, req1 = load-unit data.

---
 rtl/wb_port_arbiter_if.sv | 40 ++++
 rtl/wb_port_arbiter.sv | 95 +++++++++
 tb/tb_wb_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter_if
//  Purpose  : Bundles the writeback requester handshakes, the stall input and
//             the register-file write-port outputs of wb_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wb_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              mux_sel;
    logic [CNT_W-1:0]  conflict_cnt;

    // Requester / pipeline side: drives requests and stall, observes the port
    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data, wb_stall,
        input  req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, mux_sel, conflict_cnt
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data, wb_stall,
        output req0_ready, req1_ready, rf_we, rf_waddr, rf_wdata, mux_sel, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Round-robin arbiter sharing one register-file write port between
//             the ALU (req0) and the load unit (req1). Registered write-port
//             outputs with 1-cycle latency, registered data-mux select and a
//             saturating counter of contended cycles.
//  Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,   // synchronous, active-low
    wb_port_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_r0      = '0;

    logic              r_last_grant;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_mux_sel;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic              w_any_valid;
    logic              w_both_valid;
    logic              w_grant;       // 0 = req0, 1 = req1 (meaningful when w_any_valid)
    logic              w_accept;
    logic              w_xfer0;
    logic              w_xfer1;

    // Grant selection: lone requester wins, a tie goes to whoever did not win last
    always_comb begin
        w_any_valid  = bus.req0_valid | bus.req1_valid;
        w_both_valid = bus.req0_valid & bus.req1_valid;
        w_grant      = 1'b0;
        if (w_both_valid) begin
            w_grant = ~r_last_grant;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
        w_accept = rst & ~bus.wb_stall & w_any_valid;
        w_xfer0  = w_accept & ~w_grant;
        w_xfer1  = w_accept &  w_grant;
    end

    assign bus.req0_ready   = w_xfer0;
    assign bus.req1_ready   = w_xfer1;
    assign bus.rf_we        = r_rf_we;
    assign bus.rf_waddr     = r_rf_waddr;
    assign bus.rf_wdata     = r_rf_wdata;
    assign bus.mux_sel      = r_mux_sel;
    assign bus.conflict_cnt = r_conflict_cnt;

    // Write-port register: capture the winner, idle when nothing moves, freeze on stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_mux_sel    <= 1'b0;
            r_last_grant <= 1'b1;   // so req0 wins the first tie
        end else if (w_xfer0) begin
            r_rf_we      <= (bus.req0_rd != c_r0);  // r0 writes accepted but suppressed
            r_rf_waddr   <= bus.req0_rd;
            r_rf_wdata   <= bus.req0_data;
            r_mux_sel    <= 1'b0;
            r_last_grant <= 1'b0;
        end else if (w_xfer1) begin
            r_rf_we      <= (bus.req1_rd != c_r0);
            r_rf_waddr   <= bus.req1_rd;
            r_rf_wdata   <= bus.req1_data;
            r_mux_sel    <= 1'b1;
            r_last_grant <= 1'b1;
        end else if (!bus.wb_stall) begin
            r_rf_we      <= 1'b0;
        end
    end

    // Contention counter: counts unstalled cycles with both requesters valid, saturates
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
        end else if (w_both_valid && !bus.wb_stall && (r_conflict_cnt != c_cnt_max)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Self-checking bench for wb_port_arbiter: a behavioural model of
//             the write port checked every cycle, directed scenarios with
//             literal expectations, and a randomized handshake phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst;
    int   ntests = 0;
    int   nfail  = 0;

    wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit                m_init = 1'b0;
    int                m_last;          // requester that won most recently
    int                m_cnt;           // unbounded contention count
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_sel;

    // Expected {req1_ready, req0_ready} for the inputs currently applied
    function automatic logic [1:0] exp_ready();
        logic [1:0] r;
        r = 2'b00;
        if (rst && !bus.wb_stall) begin
            if (bus.req0_valid && bus.req1_valid) r = (m_last == 0) ? 2'b10 : 2'b01;
            else                                  r = {bus.req1_valid, bus.req0_valid};
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_init <= 1'b1;
        if (!rst) begin
            m_we <= 1'b0; m_waddr <= '0; m_wdata <= '0; m_sel <= 1'b0;
            m_cnt <= 0; m_last <= 1;
        end else if (!bus.wb_stall) begin
            if (bus.req0_valid && bus.req1_valid) m_cnt <= m_cnt + 1;
            if (exp_ready() == 2'b01) begin
                m_we <= (bus.req0_rd != 0); m_waddr <= bus.req0_rd;
                m_wdata <= bus.req0_data; m_sel <= 1'b0; m_last <= 0;
            end else if (exp_ready() == 2'b10) begin
                m_we <= (bus.req1_rd != 0); m_waddr <= bus.req1_rd;
                m_wdata <= bus.req1_data; m_sel <= 1'b1; m_last <= 1;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_init) begin
            chk("readies", {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, exp_ready()});
            chk("rf_we", 64'(bus.rf_we), 64'(m_we));
            chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
            chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
            chk("mux_sel", 64'(bus.mux_sel), 64'(m_sel));
            chk("conflict_cnt", 64'(bus.conflict_cnt), 64'((m_cnt > 255) ? 255 : m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic g[4];
    logic s[5];
    logic a0, a1;

    initial begin
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd1; bus.req0_data = 32'h1;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd2; bus.req1_data = 32'h2;
        bus.wb_stall = 1'b0;

        // T1 reset with both requesters valid
        repeat (2) tick();
        @(negedge clk);
        chk("t1_ready0", 64'(bus.req0_ready), 64'd0);
        chk("t1_ready1", 64'(bus.req1_ready), 64'd0);
        chk("t1_rf_we", 64'(bus.rf_we), 64'd0);
        chk("t1_mux_sel", 64'(bus.mux_sel), 64'd0);
        chk("t1_cnt", 64'(bus.conflict_cnt), 64'd0);

        // T2 single requester
        tick();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd7; bus.req1_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2_ready1", 64'(bus.req1_ready), 64'd1);
        tick();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("t2_rf_we", 64'(bus.rf_we), 64'd1);
        chk("t2_waddr", 64'(bus.rf_waddr), 64'd7);
        chk("t2_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        chk("t2_mux_sel", 64'(bus.mux_sel), 64'd1);

        // T3 persistent tie, new data every cycle
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req0_valid = 1'b1; bus.req0_rd = 5'(i + 10); bus.req0_data = $urandom;
            bus.req1_valid = 1'b1; bus.req1_rd = 5'(i + 20); bus.req1_data = $urandom;
            @(negedge clk);
            g[i] = bus.req1_ready;
            s[i] = bus.mux_sel;
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        s[4] = bus.mux_sel;
        chk("t3_grants", {60'd0, g[0], g[1], g[2], g[3]}, 64'b0101);
        chk("t3_mux_sel", {60'd0, s[1], s[2], s[3], s[4]}, 64'b0101);
        chk("t3_cnt", 64'(bus.conflict_cnt), 64'd4);

        // T4 stall with req0 pending
        tick();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'hA5A5A5A5;
        bus.wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_ready0", 64'(bus.req0_ready), 64'd0);
            chk("t4_waddr_frozen", 64'(bus.rf_waddr), 64'd23);
            chk("t4_cnt", 64'(bus.conflict_cnt), 64'd4);
            if (k < 2) tick();
        end
        tick();
        bus.wb_stall = 1'b0;
        @(negedge clk);
        chk("t4_release_ready0", 64'(bus.req0_ready), 64'd1);

        // T5 write to r0
        tick();
        bus.req0_rd = 5'd0; bus.req0_data = 32'h12345678;
        @(negedge clk);
        chk("t5_ready0", 64'(bus.req0_ready), 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_rf_we", 64'(bus.rf_we), 64'd0);
        chk("t5_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("t5_mux_sel", 64'(bus.mux_sel), 64'd0);

        // Randomized handshake traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a0 = bus.req0_ready;
            a1 = bus.req1_ready;
            tick();
            if (!bus.req0_valid || a0) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_rd    = 5'($urandom_range(0, 31));
                bus.req0_data  = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid || a1) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_rd    = 5'($urandom_range(0, 31));
                bus.req1_data  = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.req1_valid = 1'b0;
            end
            bus.wb_stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
            else rst = 1'b1;
        end

        // T6 saturation, then reset during a transfer
        tick();
        rst = 1'b1; bus.wb_stall = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd4; bus.req0_data = 32'h44;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd5; bus.req1_data = 32'h55;
        repeat (300) tick();
        @(negedge clk);
        chk("t6_cnt_sat", 64'(bus.conflict_cnt), 64'd255);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_in_rst", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        tick();
        @(negedge clk);
        chk("t6_rf_we", 64'(bus.rf_we), 64'd0);
        chk("t6_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("t6_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("t6_mux_sel", 64'(bus.mux_sel), 64'd0);
        chk("t6_cnt", 64'(bus.conflict_cnt), 64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_first_tie", {62'd0, bus.req1_ready, bus.req0_ready}, 64'b01);
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("t6_first_tie_sel", 64'(bus.mux_sel), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
